// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner of an 8:1 mux select with bounded hold time
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic       S2,
    output logic       S1,
    output logic       S0,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       preempt
);
    typedef enum logic {IDLE, OWN} state_t;
    localparam logic [7:0] MH = 8'(MAX_HOLD);
    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] last_q, last_d;
    logic       pre_q, pre_d;
    logic [7:0] cand;
    logic [2:0] idx, win_idx;
    logic       win_found, own_req, tmo;
    assign cand    = (state_q == OWN) ? (req & ~gnt_q) : req;
    assign own_req = |(req & gnt_q);
    assign tmo     = (MH != 8'd0) && (cnt_q == MH);
    assign {S2, S1, S0} = sel_q;
    assign gnt     = gnt_q;
    assign busy    = (state_q == OWN);
    assign preempt = pre_q;
    // first asserted candidate scanning upward from the slot after the last winner
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        idx       = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx = last_q + 3'(k);
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end
    // grant / hold / hand-over / preempt decision for the next edge
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        pre_d   = 1'b0;
        if (state_q == OWN && own_req && !(tmo && win_found)) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else if (win_found) begin
            state_d = OWN;
            gnt_d   = 8'd1 << win_idx;
            sel_d   = win_idx;
            cnt_d   = 8'd1;
            last_d  = win_idx;
            pre_d   = (state_q == OWN) && own_req;
        end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
            cnt_d   = 8'd0;
        end
    end
    // state and output registers; reset leaves priority with requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            cnt_q   <= 8'd0;
            last_q  <= 3'd7;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pre_q   <= pre_d;
        end
    end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed vectors with a scoreboard queue and an independent monitor
module tb_mux8_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       S2, S1, S0, busy, preempt;
    logic [7:0] gnt;
    int         n_vec = 0;
    int         n_err = 0;
    logic [11:0] sb_q[$];

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .S2(S2), .S1(S1), .S0(S0),
        .gnt(gnt), .busy(busy), .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s, input logic p);
        @(negedge clk);
        req = r;
        sb_q.push_back({g, s, p});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_gnt"}, int'(gnt), 0);
        chk({tag, "_sel"}, int'({S2, S1, S0}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_pre"}, int'(preempt), 0);
    endtask

    initial begin : monitor
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("gnt", int'(gnt), int'(e[11:4]));
                chk("sel", int'({S2, S1, S0}), int'(e[3:1]));
                chk("busy", int'(busy), int'(e[11:4] != 8'd0));
                chk("preempt", int'(preempt), int'(e[0]));
            end
        end
    end

    initial begin : stim
        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        step(8'h04, 8'h04, 3'd2, 1'b0);
        step(8'h00, 8'h00, 3'd2, 1'b0);
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            step(i == 0 ? 8'hFF : (8'hFF & ~(8'd1 << ((i - 1) % 8))), 8'd1 << (i % 8), 3'(i % 8), 1'b0);
            step(8'hFF, 8'd1 << (i % 8), 3'(i % 8), 1'b0);
            step(8'hFF, 8'd1 << (i % 8), 3'(i % 8), 1'b0);
        end
        step(8'h00, 8'h00, 3'd0, 1'b0);
        do_reset();
        for (int j = 0; j < 3; j++) begin
            for (int c = 0; c < 4; c++)
                step(8'h21, (j % 2) ? 8'h20 : 8'h01, (j % 2) ? 3'd5 : 3'd0, (j > 0) && (c == 0));
        end
        step(8'h00, 8'h00, 3'd0, 1'b0);
        for (int c = 0; c < 20; c++) step(8'h08, 8'h08, 3'd3, 1'b0);
        step(8'h00, 8'h00, 3'd3, 1'b0);
        step(8'h04, 8'h04, 3'd2, 1'b0);
        step(8'h44, 8'h04, 3'd2, 1'b0);
        step(8'h44, 8'h04, 3'd2, 1'b0);
        step(8'h44, 8'h04, 3'd2, 1'b0);
        step(8'h40, 8'h40, 3'd6, 1'b0);
        step(8'h00, 8'h00, 3'd6, 1'b0);
        step(8'h80, 8'h80, 3'd7, 1'b0);
        step(8'h80, 8'h80, 3'd7, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        @(negedge clk);
        req = 8'h81;
        rst_n = 1'b1;
        sb_q.push_back({8'h01, 3'd0, 1'b0});
        step(8'h80, 8'h80, 3'd7, 1'b0);
        step(8'h00, 8'h00, 3'd7, 1'b0);
        @(posedge clk);
        #2;
        chk("drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
